// File: rtl/between_to_fifo.sv
// between_to_fifo: receive side of the inter-board parallel link.
// Bytes arrive on t_data under a 4-phase tsent/trecieve handshake and are
// pushed into the local FIFO. A running CRC8 (poly 0x07, MSB-first) and a
// byte count are kept per frame; isFinish flags a completed frame.
// Optional feature macro: BETWEEN_PARITY_EN (adds odd-parity input tparity).
module between_to_fifo #(
  parameter int          FRAME_LEN = 16,
  parameter logic [7:0]  CRC_INIT  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] t_data,
  input  logic       tsent,
`ifdef BETWEEN_PARITY_EN
  input  logic       tparity,
`endif
  output logic       trecieve,
  output logic [7:0] fifo_data_out,
  output logic       fifo_we,
  input  logic       fifo_busy,
  input  logic       fifo_full,
  output logic [7:0] CRC,
  output logic [9:0] byte_count,
  output logic [3:0] error,
  output logic       isFinish
);

  localparam logic [9:0] FRAME_LEN_W = 10'(FRAME_LEN);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    WRITE   = 3'd2,
    ACK     = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic        tsentMeta;
  logic        tsentSync;
  logic [7:0]  dataReg;
  logic [7:0]  crcReg;
  logic [9:0]  countReg;
  logic        fullErrReg;
  logic        parityErrReg;
  logic        writeEn;
  logic        dropFull;
  logic        dropParity;
  logic        parityBad;
  logic [7:0]  crcNext;

  // One byte of CRC8, polynomial x^8+x^2+x+1, MSB first, no reflection.
  function automatic logic [7:0] crc8Byte(input logic [7:0] seed);
    logic [7:0] c;
    c = seed;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  assign crcNext = crc8Byte(crcReg ^ dataReg);

`ifdef BETWEEN_PARITY_EN
  logic parityReg;
  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  assign parityBad = ~(^{dataReg, parityReg});
`else
  assign parityBad = 1'b0;
`endif

  // Two-flop synchronizer for the remote strobe, which is asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tsentMeta <= 1'b0;
      tsentSync <= 1'b0;
    end else begin
      tsentMeta <= tsent;
      tsentSync <= tsentMeta;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state and write/drop decisions; enable low forces IDLE with no write.
  always_comb begin
    stateNext  = state;
    writeEn    = 1'b0;
    dropFull   = 1'b0;
    dropParity = 1'b0;
    if (!enable) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (tsentSync) stateNext = CAPTURE;
        CAPTURE: stateNext = WRITE;
        WRITE: begin
          if (!fifo_busy) begin
            stateNext = ACK;
            if (fifo_full)      dropFull   = 1'b1;
            else if (parityBad) dropParity = 1'b1;
            else                writeEn    = 1'b1;
          end
        end
        ACK: begin
          // Hold the acknowledge until the sender withdraws its strobe.
          if (!tsentSync) stateNext = (countReg == FRAME_LEN_W) ? DONE : IDLE;
        end
        DONE:    stateNext = DONE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Datapath: capture byte, advance CRC/count on a real write, record drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataReg      <= 8'h00;
      crcReg       <= CRC_INIT;
      countReg     <= 10'd0;
      fullErrReg   <= 1'b0;
      parityErrReg <= 1'b0;
`ifdef BETWEEN_PARITY_EN
      parityReg    <= 1'b0;
`endif
    end else if (!enable) begin
      crcReg       <= CRC_INIT;
      countReg     <= 10'd0;
      fullErrReg   <= 1'b0;
      parityErrReg <= 1'b0;
    end else begin
      if (state == CAPTURE) begin
        dataReg <= t_data;
`ifdef BETWEEN_PARITY_EN
        parityReg <= tparity;
`endif
      end
      if (writeEn) begin
        crcReg   <= crcNext;
        countReg <= countReg + 10'd1;
      end
      if (dropFull)   fullErrReg   <= 1'b1;
      if (dropParity) parityErrReg <= 1'b1;
    end
  end

  assign trecieve      = (state == ACK);
  assign isFinish      = (state == DONE);
  assign fifo_we       = writeEn;
  assign fifo_data_out = dataReg;
  assign CRC           = crcReg;
  assign byte_count    = countReg;
  assign error         = {2'b00, parityErrReg, fullErrReg};

endmodule

// File: tb/tb_between_to_fifo.sv
// Scoreboard bench for between_to_fifo (FRAME_LEN=2). Stimulus pushes the
// expected FIFO write (data, cycle, CRC/count after) into a queue; a monitor
// pops and compares on every fifo_we.
module tb_between_to_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] t_data;
  logic       tsent;
  logic       tparity;
  logic       trecieve;
  logic [7:0] fifo_data_out;
  logic       fifo_we;
  logic       fifo_busy;
  logic       fifo_full;
  logic [7:0] CRC;
  logic [9:0] byte_count;
  logic [3:0] error;
  logic       isFinish;

  between_to_fifo #(.FRAME_LEN(2), .CRC_INIT(8'h00)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .t_data(t_data),
    .tsent(tsent),
`ifdef BETWEEN_PARITY_EN
    .tparity(tparity),
`endif
    .trecieve(trecieve),
    .fifo_data_out(fifo_data_out),
    .fifo_we(fifo_we),
    .fifo_busy(fifo_busy),
    .fifo_full(fifo_full),
    .CRC(CRC),
    .byte_count(byte_count),
    .error(error),
    .isFinish(isFinish)
  );

  always #5 clk = ~clk;

  int cycleCount = 0;
  always @(posedge clk) cycleCount++;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] data;
    int         cycle;
    logic [7:0] crc;
    logic [9:0] cnt;
  } exp_t;
  exp_t expQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycleCount);
    end else begin
      $display("ok   %s = %0h (cycle %0d)", name, act, cycleCount);
    end
  endtask

  // Monitor: samples 1 ns before each rising edge; inputs change on falling edges.
  initial begin
    exp_t       e;
    logic       pending;
    logic [7:0] pc;
    logic [9:0] pn;
    pending = 1'b0;
    pc = 8'h00;
    pn = 10'd0;
    forever begin
      @(negedge clk);
      #4;
      if (pending) begin
        check("crc_after_write", CRC, pc);
        check("count_after_write", byte_count, pn);
        pending = 1'b0;
      end
      if (fifo_we === 1'b1) begin
        if (expQ.size() == 0) begin
          check("unexpected_fifo_we", fifo_we, 0);
        end else begin
          e = expQ.pop_front();
          check("write_data", fifo_data_out, e.data);
          check("write_cycle", cycleCount, e.cycle);
          pc = e.crc;
          pn = e.cnt;
          pending = 1'b1;
        end
      end
    end
  end

  // One handshake; optionally leaves tsent high (for the mid-ACK reset test).
  task automatic sendByte(input logic [7:0] d, input bit expectWrite,
                          input logic [7:0] crcAfter, input logic [9:0] cntAfter,
                          input int busyCycles, input bit releaseStrobe);
    int n;
    int k;
    @(negedge clk);
    t_data = d;
    tsent  = 1'b1;
    n = cycleCount;
    if (busyCycles > 0) fifo_busy = 1'b1;
    if (expectWrite) expQ.push_back('{d, n + 4 + busyCycles, crcAfter, cntAfter});
    if (busyCycles > 0) begin
      while (cycleCount < n + 4 + busyCycles) @(negedge clk);
      fifo_busy = 1'b0;
    end
    k = 0;
    while (trecieve !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("ack_rise", trecieve, 1);
    repeat (3) @(negedge clk);
    check("ack_hold", trecieve, 1);
    if (releaseStrobe) begin
      tsent = 1'b0;
      k = 0;
      while (trecieve !== 1'b0 && k < 40) begin
        @(negedge clk);
        k++;
      end
      check("ack_fall", trecieve, 0);
    end
  endtask

  task automatic restartFrame();
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("restart_crc", CRC, 8'h00);
    check("restart_count", byte_count, 0);
    check("restart_error", error, 0);
    check("restart_isFinish", isFinish, 0);
    enable = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bit seenAck;
    reset = 1'b1; enable = 1'b0; tsent = 1'b0; t_data = 8'h00;
    tparity = 1'b0; fifo_busy = 1'b0; fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_trecieve", trecieve, 0);
    check("rst_fifo_we", fifo_we, 0);
    check("rst_crc", CRC, 8'h00);
    check("rst_count", byte_count, 0);
    check("rst_error", error, 0);
    check("rst_isFinish", isFinish, 0);
    reset = 1'b0;
    enable = 1'b1;
    @(negedge clk);

    // Single byte 0x01 -> CRC 07, count 1, write 4 clk after tsent.
    sendByte(8'h01, 1'b1, 8'h07, 10'd1, 0, 1'b1);
    // Second byte 0x02 -> CRC 1B, count 2, frame complete.
    sendByte(8'h02, 1'b1, 8'h1B, 10'd2, 0, 1'b1);
    check("frame_isFinish", isFinish, 1);
    // A third strobe in DONE must not be acknowledged.
    @(negedge clk);
    t_data = 8'h33;
    tsent = 1'b1;
    seenAck = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (trecieve === 1'b1) seenAck = 1'b1;
    end
    check("done_no_ack", seenAck, 0);
    tsent = 1'b0;
    restartFrame();

    // fifo_busy held 5 cycles in WRITE: write delayed by 5, CRC(A5)=72.
    sendByte(8'hA5, 1'b1, 8'h72, 10'd1, 5, 1'b1);
    restartFrame();

    // Full FIFO: byte dropped, error[0] set, handshake still completes.
    fifo_full = 1'b1;
    sendByte(8'h3C, 1'b0, 8'h00, 10'd0, 0, 1'b1);
    fifo_full = 1'b0;
    check("full_error", error, 4'b0001);
    check("full_count", byte_count, 0);
    check("full_crc", CRC, 8'h00);
    restartFrame();

`ifdef BETWEEN_PARITY_EN
    tparity = 1'b0;
    sendByte(8'h07, 1'b1, 8'h15, 10'd1, 0, 1'b1);
    tparity = 1'b1;
    sendByte(8'h07, 1'b0, 8'h00, 10'd0, 0, 1'b1);
    tparity = 1'b0;
    check("parity_error", error, 4'b0010);
    check("parity_count", byte_count, 1);
    check("parity_crc", CRC, 8'h15);
    restartFrame();
`endif

    // Reset in the middle of an ACK drops everything immediately.
    sendByte(8'h01, 1'b1, 8'h07, 10'd1, 0, 1'b1);
    fifo_full = 1'b1;
    sendByte(8'h55, 1'b0, 8'h00, 10'd0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midack_trecieve", trecieve, 0);
    check("midack_fifo_we", fifo_we, 0);
    check("midack_crc", CRC, 8'h00);
    check("midack_count", byte_count, 0);
    check("midack_isFinish", isFinish, 0);
    tsent = 1'b0;
    fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_drained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
